// File: rtl/text_writer_pkg.sv
// Shared screen geometry, control codes and enums for the text-mode writer.
// Optional build macro TEXT_WRITER_CLEAR_ON_RESET_EN is consumed by text_writer.
package text_mode_pkg;

    localparam int SCREEN_COLS = 80;
    localparam int SCREEN_ROWS = 25;
    localparam int COL_W       = 7;
    localparam int ROW_W       = 5;
    localparam int ADDR_W      = ROW_W + COL_W;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] DEFAULT_BLANK    = 8'h20;
    localparam logic [7:0] RESET_CLEAR_COLR = 8'hFC;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ADVANCE,
        CMD_NEWLINE,
        CMD_CR,
        CMD_BACK,
        CMD_HOME
    } cursor_cmd_e;

endpackage

// File: rtl/text_writer_if.sv
// Character/colour input stream. Handshake: a transfer happens on the rising
// clock edge where valid_i and ready_o are both high; the source holds data while valid_i && !ready_o.
interface text_writer_if;
    logic [7:0] char_i;
    logic [7:0] colr_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output char_i, output colr_i, output valid_i, input ready_o);
    modport slave  (input char_i, input colr_i, input valid_i, output ready_o);
endinterface

// File: rtl/text_writer_cursor.sv
// Column/row counter with explicit wrap at COLS-1 / ROWS-1; used both for the
// text cursor and for the clear-sweep address.
module text_cursor
    import text_mode_pkg::*;
#(
    parameter int COLS = SCREEN_COLS,
    parameter int ROWS = SCREEN_ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cursor_cmd_e       cmd_i,
    output logic [COL_W-1:0]  x_o,
    output logic [ROW_W-1:0]  y_o,
    output logic              last_o
);

    localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [ROW_W-1:0] y_next;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        y_next = (y_q == Y_MAX) ? '0 : y_q + ROW_W'(1);
        case (cmd_i)
            CMD_ADVANCE: begin
                if (x_q == X_MAX) begin
                    x_d = '0;
                    y_d = y_next;
                end else begin
                    x_d = x_q + COL_W'(1);
                end
            end
            CMD_NEWLINE: begin
                x_d = '0;
                y_d = y_next;
            end
            CMD_CR:   x_d = '0;
            CMD_BACK: if (x_q != '0) x_d = x_q - COL_W'(1);
            CMD_HOME: begin
                x_d = '0;
                y_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/text_writer.sv
// Text-mode writer: consumes char/colour pairs, tracks the cursor and writes the
// screen/colour RAMs. Define TEXT_WRITER_CLEAR_ON_RESET_EN to sweep-clear after reset.
module text_writer
    import text_mode_pkg::*;
#(
    parameter int         COLS       = SCREEN_COLS,
    parameter int         ROWS       = SCREEN_ROWS,
    parameter logic [7:0] BLANK_CHAR = DEFAULT_BLANK
) (
    input  logic              clk,
    input  logic              rst_n,
    text_writer_if.slave      in_if,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_char_o,
    output logic [7:0]        wr_colr_o,
    output logic              wren_s_o,
    output logic              wren_c_o,
    output logic [COL_W-1:0]  cursor_x_o,
    output logic [ROW_W-1:0]  cursor_y_o,
    output logic              busy_o,
    output state_e            dbg_state_o
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        char_q, char_d;
    logic [7:0]        colr_q, colr_d;
    logic [7:0]        clr_colr_q, clr_colr_d;

    cursor_cmd_e       cur_cmd, swp_cmd;
    logic [COL_W-1:0]  cur_x, swp_x;
    logic [ROW_W-1:0]  cur_y, swp_y;
    logic              cur_last, swp_last;
    logic              xfer;

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_i  (cur_cmd),
        .x_o    (cur_x),
        .y_o    (cur_y),
        .last_o (cur_last)
    );

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_i  (swp_cmd),
        .x_o    (swp_x),
        .y_o    (swp_y),
        .last_o (swp_last)
    );

    assign xfer = in_if.valid_i && ready_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        char_d     = char_q;
        colr_d     = colr_q;
        clr_colr_d = clr_colr_q;
        cur_cmd    = CMD_NONE;
        swp_cmd    = CMD_NONE;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    case (in_if.char_i)
                        CH_CR: cur_cmd = CMD_CR;
                        CH_LF: cur_cmd = CMD_NEWLINE;
                        CH_BS: begin
                            if (cur_x != '0) begin
                                addr_d  = {cur_y, cur_x - COL_W'(1)};
                                char_d  = BLANK_CHAR;
                                colr_d  = in_if.colr_i;
                                wren_d  = 1'b1;
                                cur_cmd = CMD_BACK;
                            end
                        end
                        CH_FF: begin
                            clr_colr_d = in_if.colr_i;
                            state_d    = ST_CLEAR;
                            ready_d    = 1'b0;
                            busy_d     = 1'b1;
                            swp_cmd    = CMD_HOME;
                        end
                        default: begin
                            addr_d  = {cur_y, cur_x};
                            char_d  = in_if.char_i;
                            colr_d  = in_if.colr_i;
                            wren_d  = 1'b1;
                            cur_cmd = CMD_ADVANCE;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                addr_d  = {swp_y, swp_x};
                char_d  = BLANK_CHAR;
                colr_d  = clr_colr_q;
                wren_d  = 1'b1;
                swp_cmd = CMD_ADVANCE;
                // Last cell is being written this edge; hand back to IDLE now so
                // ready rises in the cycle that shows the final write.
                if (swp_last) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    cur_cmd = CMD_HOME;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
            state_q    <= ST_CLEAR;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            clr_colr_q <= RESET_CLEAR_COLR;
`else
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            clr_colr_q <= '0;
`endif
            wren_q     <= 1'b0;
            addr_q     <= '0;
            char_q     <= '0;
            colr_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            clr_colr_q <= clr_colr_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            char_q     <= char_d;
            colr_q     <= colr_d;
        end
    end

    logic unused_cur_last;
    assign unused_cur_last = cur_last;

    assign in_if.ready_o = ready_q;
    assign wr_addr_o     = addr_q;
    assign wr_char_o     = char_q;
    assign wr_colr_o     = colr_q;
    assign wren_s_o      = wren_q;
    assign wren_c_o      = wren_q;
    assign cursor_x_o    = cur_x;
    assign cursor_y_o    = cur_y;
    assign busy_o        = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: write scoreboard plus per-scenario tasks.
module tb_text_writer;
    import text_mode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [11:0] wr_addr_o;
    logic [7:0]  wr_char_o;
    logic [7:0]  wr_colr_o;
    logic        wren_s_o;
    logic        wren_c_o;
    logic [6:0]  cursor_x_o;
    logic [4:0]  cursor_y_o;
    logic        busy_o;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];
    int mx = 0;
    int my = 0;

    text_writer_if in_if ();

    text_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (in_if),
        .wr_addr_o   (wr_addr_o),
        .wr_char_o   (wr_char_o),
        .wr_colr_o   (wr_colr_o),
        .wren_s_o    (wren_s_o),
        .wren_c_o    (wren_c_o),
        .cursor_x_o  (cursor_x_o),
        .cursor_y_o  (cursor_y_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && (wren_s_o || wren_c_o)) begin
            logic [27:0] got;
            logic [27:0] exp;
            got = {wr_addr_o, wr_char_o, wr_colr_o};
            checks++;
            if (wren_s_o !== wren_c_o) begin
                errors++;
                $display("FAIL wren_pair got s=%b c=%b need equal", wren_s_o, wren_c_o);
            end else if (wr_addr_o[6:0] >= 7'd80 || wr_addr_o[11:7] >= 5'd25) begin
                errors++;
                $display("FAIL write_range got addr=%h need col<80 row<25", wr_addr_o);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h char=%h colr=%h need none",
                         wr_addr_o, wr_char_o, wr_colr_o);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write_data got %h/%h/%h need %h/%h/%h",
                             got[27:16], got[15:8], got[7:0], exp[27:16], exp[15:8], exp[7:0]);
                end
            end
        end
    end

    task automatic push_write(input int row, input int col, input logic [7:0] ch, input logic [7:0] co);
        logic [4:0] r5;
        logic [6:0] c7;
        r5 = 5'(row);
        c7 = 7'(col);
        exp_q.push_back({r5, c7, ch, co});
    endtask

    task automatic model_accept(input logic [7:0] ch, input logic [7:0] co);
        case (ch)
            8'h0D: mx = 0;
            8'h0A: begin
                mx = 0;
                my = (my == 24) ? 0 : my + 1;
            end
            8'h08: begin
                if (mx > 0) begin
                    mx = mx - 1;
                    push_write(my, mx, 8'h20, co);
                end
            end
            8'h0C: begin
                for (int r = 0; r < 25; r++)
                    for (int c = 0; c < 80; c++)
                        push_write(r, c, 8'h20, co);
                mx = 0;
                my = 0;
            end
            default: begin
                push_write(my, mx, ch, co);
                if (mx == 79) begin
                    mx = 0;
                    my = (my == 24) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        endcase
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] ch, input logic [7:0] co);
        int waits;
        in_if.char_i  = ch;
        in_if.colr_i  = co;
        in_if.valid_i = 1'b1;
        waits = 0;
        while (in_if.ready_o !== 1'b1 && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (in_if.ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_ready got ready=%b need 1", in_if.ready_o);
        end else begin
            model_accept(ch, co);
        end
        @(negedge clk);
        in_if.valid_i = 1'b0;
    endtask

    task automatic send_printable();
        logic [7:0] ch;
        logic [7:0] co;
        ch = 8'($urandom_range(8'h21, 8'h7E));
        co = 8'($urandom_range(0, 255));
        send(ch, co);
    endtask

    task automatic drain(input string name);
        int waits;
        waits = 0;
        while (exp_q.size() != 0 && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending writes need 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_addr_o, wr_char_o, wr_colr_o, wren_s_o, wren_c_o, busy_o} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h char=%h colr=%h ws=%b wc=%b busy=%b need zeros",
                     wr_addr_o, wr_char_o, wr_colr_o, wren_s_o, wren_c_o, busy_o);
        end
        checks++;
        if (in_if.ready_o !== 1'b1 || dbg_state !== ST_IDLE || {cursor_y_o, cursor_x_o} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state got ready=%b state=%0d cur=(%0d,%0d) need 1/IDLE/(0,0)",
                     in_if.ready_o, dbg_state, cursor_x_o, cursor_y_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_if.ready_o !== 1'b1 || busy_o !== 1'b0 || wren_s_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got ready=%b busy=%b wren=%b need 1/0/0", in_if.ready_o, busy_o, wren_s_o);
        end
    endtask

    task automatic test_printable();
        send(8'h41, 8'hFC);
        checks++;
        if (exp_q.size() != 1 || exp_q[0] !== {12'h000, 8'h41, 8'hFC}) begin
            errors++;
            $display("FAIL printable_expect got %0d queued need 1 of 000/41/FC", exp_q.size());
        end
        checks++;
        if (cursor_x_o !== 7'd1 || cursor_y_o !== 5'd0) begin
            errors++;
            $display("FAIL printable_cursor got (%0d,%0d) need (1,0)", cursor_x_o, cursor_y_o);
        end
        checks++;
        if (wren_s_o !== 1'b1) begin
            errors++;
            $display("FAIL printable_pulse got wren=%b need 1", wren_s_o);
        end
        @(negedge clk);
        checks++;
        if (wren_s_o !== 1'b0) begin
            errors++;
            $display("FAIL printable_one_cycle got wren=%b need 0", wren_s_o);
        end
        drain("printable");
    endtask

    task automatic test_back_to_back();
        send(8'h0D, 8'h00);
        for (int i = 0; i < 80; i++) send_printable();
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd1) begin
            errors++;
            $display("FAIL line_wrap_cursor got (%0d,%0d) need (0,1)", cursor_x_o, cursor_y_o);
        end
        send(8'h42, 8'h11);
        checks++;
        if (exp_q[exp_q.size()-1] !== {12'h080, 8'h42, 8'h11}) begin
            errors++;
            $display("FAIL line_wrap_next got %h need 080/42/11", exp_q[exp_q.size()-1]);
        end
        drain("back_to_back");
    endtask

    task automatic test_screen_wrap();
        send(8'h0D, 8'h00);
        for (int i = 0; i < 23; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 79; i++) send_printable();
        checks++;
        if (cursor_x_o !== 7'd79 || cursor_y_o !== 5'd24) begin
            errors++;
            $display("FAIL screen_wrap_pre got (%0d,%0d) need (79,24)", cursor_x_o, cursor_y_o);
        end
        drain("screen_wrap_fill");
        send(8'h5A, 8'hC0);
        checks++;
        if (exp_q.size() != 1 || exp_q[0] !== {12'hC4F, 8'h5A, 8'hC0}) begin
            errors++;
            $display("FAIL screen_wrap_expect got %0d queued need 1 of C4F/5A/C0", exp_q.size());
        end
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd0) begin
            errors++;
            $display("FAIL screen_wrap_cursor got (%0d,%0d) need (0,0)", cursor_x_o, cursor_y_o);
        end
        drain("screen_wrap");
    endtask

    task automatic test_backspace();
        for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send_printable();
        drain("bs_setup");
        send(8'h08, 8'h5A);
        checks++;
        if (exp_q.size() != 1 || exp_q[0] !== {12'h184, 8'h20, 8'h5A}) begin
            errors++;
            $display("FAIL bs_expect got %0d queued need 1 of 184/20/5A", exp_q.size());
        end
        checks++;
        if (cursor_x_o !== 7'd4 || cursor_y_o !== 5'd3) begin
            errors++;
            $display("FAIL bs_cursor got (%0d,%0d) need (4,3)", cursor_x_o, cursor_y_o);
        end
        drain("backspace");
    endtask

    task automatic test_control();
        send_printable();
        drain("ctl_setup");
        send(8'h0D, 8'h77);
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd3 || wren_s_o !== 1'b0) begin
            errors++;
            $display("FAIL cr got (%0d,%0d) wren=%b need (0,3) 0", cursor_x_o, cursor_y_o, wren_s_o);
        end
        send(8'h0A, 8'h77);
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd4 || wren_s_o !== 1'b0) begin
            errors++;
            $display("FAIL lf got (%0d,%0d) wren=%b need (0,4) 0", cursor_x_o, cursor_y_o, wren_s_o);
        end
        send(8'h08, 8'h77);
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd4 || wren_s_o !== 1'b0) begin
            errors++;
            $display("FAIL bs_col0 got (%0d,%0d) wren=%b need (0,4) 0", cursor_x_o, cursor_y_o, wren_s_o);
        end
        drain("control");
    endtask

    task automatic test_clear();
        int busy_cycles;
        int bad_ready;
        in_if.char_i  = 8'h0C;
        in_if.colr_i  = 8'h30;
        in_if.valid_i = 1'b1;
        model_accept(8'h0C, 8'h30);
        @(negedge clk);
        in_if.char_i = 8'h51;
        in_if.colr_i = 8'h99;
        checks++;
        if (dbg_state !== ST_CLEAR) begin
            errors++;
            $display("FAIL clear_state got %0d need CLEAR", dbg_state);
        end
        busy_cycles = 0;
        bad_ready   = 0;
        while (busy_o === 1'b1 && busy_cycles < 2100) begin
            if (in_if.ready_o !== 1'b0) bad_ready++;
            busy_cycles++;
            @(negedge clk);
        end
        in_if.valid_i = 1'b0;
        checks++;
        if (busy_cycles != 2000) begin
            errors++;
            $display("FAIL clear_busy_len got %0d need 2000", busy_cycles);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL clear_ready_low got %0d ready-high cycles need 0", bad_ready);
        end
        checks++;
        if (in_if.ready_o !== 1'b1 || cursor_x_o !== 7'd0 || cursor_y_o !== 5'd0) begin
            errors++;
            $display("FAIL clear_done got ready=%b cur=(%0d,%0d) need 1 (0,0)",
                     in_if.ready_o, cursor_x_o, cursor_y_o);
        end
        drain("clear");
        checks++;
        if (cursor_x_o !== 7'd0 || cursor_y_o !== 5'd0) begin
            errors++;
            $display("FAIL clear_held_valid got cur=(%0d,%0d) need (0,0)", cursor_x_o, cursor_y_o);
        end
    endtask

    task automatic test_reset_mid_clear();
        send(8'h0C, 8'h0F);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || in_if.ready_o !== 1'b1 || wren_s_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_abort got busy=%b ready=%b wren=%b state=%0d need 0/1/0/IDLE",
                     busy_o, in_if.ready_o, wren_s_o, dbg_state);
        end
        exp_q.delete();
        mx = 0;
        my = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h43, 8'h0C);
        checks++;
        if (exp_q.size() != 1 || exp_q[0] !== {12'h000, 8'h43, 8'h0C}) begin
            errors++;
            $display("FAIL after_abort_expect got %0d queued need 1 of 000/43/0C", exp_q.size());
        end
        drain("after_abort");
    endtask

    initial begin
        rst_n         = 1'b0;
        in_if.valid_i = 1'b0;
        in_if.char_i  = 8'h00;
        in_if.colr_i  = 8'h00;
        test_reset();
        test_printable();
        test_back_to_back();
        test_screen_wrap();
        test_backspace();
        test_control();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
